// File: rtl/hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hazard_ctrl                                                      |
// | Purpose  : 5-stage RV32I pipeline hazard controller. Generates per-stage    |
// |            stall/nop controls (combinational) and registered EX operand     |
// |            forwarding selects; covers dmem, store-hold, branch flush,       |
// |            load-use, stall-only interlock and imem events.                  |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module hazard_ctrl #(
  parameter int REG_W      = 5,
  parameter int FWD_EN     = 1,
  parameter int RF_BYPASS  = 1,
  parameter int STORE_HOLD = 2,
  parameter int BR_STAGE   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs1_id,
  input  logic [REG_W-1:0] rs2_id,
  input  logic             rs1_used,
  input  logic             rs2_used,
  input  logic [REG_W-1:0] rd_ex,
  input  logic [REG_W-1:0] rd_mem,
  input  logic [REG_W-1:0] rd_wb,
  input  logic             we_ex,
  input  logic             we_mem,
  input  logic             we_wb,
  input  logic             load_ex,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             branch_taken,
  input  logic             iready_n,
  input  logic             dready_n,
  input  logic             dbusy,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             stall_wb,
  output logic             nop_if,
  output logic             nop_id,
  output logic             nop_ex,
  output logic             nop_mem,
  output logic             nop_wb,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  localparam int   CNT_W    = (STORE_HOLD > 0) ? $clog2(STORE_HOLD + 1) : 1;
  localparam logic C_FWD    = (FWD_EN != 0);
  localparam logic C_RF_BYP = (RF_BYPASS != 0);
  localparam logic C_SH_EN  = (STORE_HOLD > 0);
  localparam logic C_BR_MEM = (BR_STAGE == 3);
  localparam logic [CNT_W-1:0] C_HOLD_LOAD = CNT_W'(STORE_HOLD);
  localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_DONE = 2'd2
  } sh_state_t;

  sh_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  // A producer matches only when it writes a nonzero register the consumer reads.
  function automatic logic f_match(input logic [REG_W-1:0] rs, input logic used,
                                   input logic [REG_W-1:0] rd, input logic we);
    return used & we & (rd != '0) & (rs == rd);
  endfunction

  // Youngest producer wins; the WB value only needs forwarding without RF bypass.
  function automatic logic [1:0] f_sel(input logic ex, input logic mem, input logic wb);
    if (ex)                  return 2'b01;
    else if (mem)            return 2'b10;
    else if (wb & ~C_RF_BYP) return 2'b11;
    else                     return 2'b00;
  endfunction

  logic w_ex_a, w_ex_b, w_mem_a, w_mem_b, w_wb_a, w_wb_b;
  logic w_dmem_ext, w_arm, w_dmem_stall, w_load_use, w_interlock;

  assign w_ex_a  = f_match(rs1_id, rs1_used, rd_ex,  we_ex);
  assign w_ex_b  = f_match(rs2_id, rs2_used, rd_ex,  we_ex);
  assign w_mem_a = f_match(rs1_id, rs1_used, rd_mem, we_mem);
  assign w_mem_b = f_match(rs2_id, rs2_used, rd_mem, we_mem);
  assign w_wb_a  = f_match(rs1_id, rs1_used, rd_wb,  we_wb);
  assign w_wb_b  = f_match(rs2_id, rs2_used, rd_wb,  we_wb);

  // The arming cycle already holds the store in MEM so the hold covers that store.
  assign w_dmem_ext   = dbusy | (mem_read & dready_n);
  assign w_arm        = C_SH_EN & (r_state == S_IDLE) & mem_write & ~w_dmem_ext;
  assign w_dmem_stall = w_dmem_ext | (r_state == S_HOLD) | w_arm;

  assign w_load_use  = C_FWD & load_ex & (w_ex_a | w_ex_b);
  assign w_interlock = ~C_FWD & (w_ex_a | w_ex_b | w_mem_a | w_mem_b |
                                 (~C_RF_BYP & (w_wb_a | w_wb_b)));

  // Store-hold state and counter register; reset aborts any hold in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Store-hold next state: count down in HOLD, release once in DONE, no re-arm.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_arm) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = C_HOLD_LOAD;
        end
      end
      S_HOLD: begin
        if (r_cnt <= C_ONE) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt - C_ONE;
        end
      end
      S_DONE: begin
        if (!w_dmem_stall) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Prioritised stall/nop generation: rst > dmem > branch > load-use/interlock > imem.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    stall_wb  = 1'b0;
    nop_if    = 1'b0;
    nop_id    = 1'b0;
    nop_ex    = 1'b0;
    nop_mem   = 1'b0;
    nop_wb    = 1'b0;
    if (rst) begin
      nop_if  = 1'b1;
      nop_id  = 1'b1;
      nop_ex  = 1'b1;
      nop_mem = 1'b1;
      nop_wb  = 1'b1;
    end else if (w_dmem_stall) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
      nop_wb    = 1'b1;
    end else if (branch_taken) begin
      nop_if  = 1'b1;
      nop_id  = 1'b1;
      nop_ex  = 1'b1;
      nop_mem = C_BR_MEM;
    end else if (w_load_use | w_interlock) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      nop_ex   = 1'b1;
    end else if (iready_n) begin
      stall_if = 1'b1;
      nop_id   = 1'b1;
    end
  end

  generate
    if (FWD_EN != 0) begin : g_fwd
      // Capture forwarding selects as ID advances; bubbles load 00, stalls hold.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          fwd_a <= 2'b00;
          fwd_b <= 2'b00;
        end else if (!stall_ex) begin
          if (nop_ex) begin
            fwd_a <= 2'b00;
            fwd_b <= 2'b00;
          end else begin
            fwd_a <= f_sel(w_ex_a, w_mem_a, w_wb_a);
            fwd_b <= f_sel(w_ex_b, w_mem_b, w_wb_b);
          end
        end
      end
    end else begin : g_nofwd
      assign fwd_a = 2'b00;
      assign fwd_b = 2'b00;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_hazard_ctrl                                                   |
// | Purpose  : Directed self-checking bench for hazard_ctrl (forwarding         |
// |            instance plus stall-only / BR_STAGE=2 instance).                 |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_id, rs2_id, rd_ex, rd_mem, rd_wb;
  logic       rs1_used, rs2_used, we_ex, we_mem, we_wb, load_ex;
  logic       mem_read, mem_write, branch_taken, iready_n, dready_n, dbusy;

  // stall/nop vectors ordered {if, id, ex, mem, wb}
  logic [4:0] f_st, f_nop, i_st, i_nop;
  logic [1:0] f_fa, f_fb, i_fa, i_fb;

  int total;
  int bad;

  always #5 clk = ~clk;

  hazard_ctrl u_fwd (
    .clk(clk), .rst(rst),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
    .we_ex(we_ex), .we_mem(we_mem), .we_wb(we_wb), .load_ex(load_ex),
    .mem_read(mem_read), .mem_write(mem_write), .branch_taken(branch_taken),
    .iready_n(iready_n), .dready_n(dready_n), .dbusy(dbusy),
    .stall_if(f_st[4]), .stall_id(f_st[3]), .stall_ex(f_st[2]),
    .stall_mem(f_st[1]), .stall_wb(f_st[0]),
    .nop_if(f_nop[4]), .nop_id(f_nop[3]), .nop_ex(f_nop[2]),
    .nop_mem(f_nop[1]), .nop_wb(f_nop[0]),
    .fwd_a(f_fa), .fwd_b(f_fb)
  );

  hazard_ctrl #(.FWD_EN(0), .RF_BYPASS(0), .STORE_HOLD(2), .BR_STAGE(2)) u_il (
    .clk(clk), .rst(rst),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
    .we_ex(we_ex), .we_mem(we_mem), .we_wb(we_wb), .load_ex(load_ex),
    .mem_read(mem_read), .mem_write(mem_write), .branch_taken(branch_taken),
    .iready_n(iready_n), .dready_n(dready_n), .dbusy(dbusy),
    .stall_if(i_st[4]), .stall_id(i_st[3]), .stall_ex(i_st[2]),
    .stall_mem(i_st[1]), .stall_wb(i_st[0]),
    .nop_if(i_nop[4]), .nop_id(i_nop[3]), .nop_ex(i_nop[2]),
    .nop_mem(i_nop[1]), .nop_wb(i_nop[0]),
    .fwd_a(i_fa), .fwd_b(i_fb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    rs1_id = '0; rs2_id = '0; rs1_used = 1'b0; rs2_used = 1'b0;
    rd_ex = '0; rd_mem = '0; rd_wb = '0;
    we_ex = 1'b0; we_mem = 1'b0; we_wb = 1'b0; load_ex = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; branch_taken = 1'b0;
    iready_n = 1'b0; dready_n = 1'b0; dbusy = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    set_idle();

    // reset state
    #3;
    chk("rst_stall",    f_st,  5'b00000);
    chk("rst_nop",      f_nop, 5'b11111);
    chk("rst_il_nop",   i_nop, 5'b11111);
    tick(); tick();
    chk("rst_fwd_a",    f_fa,  2'b00);
    chk("rst_fwd_b",    f_fb,  2'b00);
    chk("rst_state",    u_fwd.r_state, 2'd0);
    chk("rst_cnt",      u_fwd.r_cnt,   2'd0);
    #3 rst = 1'b0;
    #1;
    chk("idle_stall",   f_st,  5'b00000);
    chk("idle_nop",     f_nop, 5'b00000);
    tick();

    // load-use: lw x5 in EX, ID reads x5
    load_ex = 1'b1; rd_ex = 5'd5; we_ex = 1'b1; rs1_id = 5'd5; rs1_used = 1'b1;
    #1;
    chk("lu_stall",     f_st,  5'b11000);
    chk("lu_nop",       f_nop, 5'b00100);
    tick();
    chk("lu_fwd_bubble", f_fa, 2'b00);
    load_ex = 1'b0; rd_ex = 5'd0; we_ex = 1'b0; rd_mem = 5'd5; we_mem = 1'b1;
    #1;
    chk("lu_next_stall", f_st,  5'b00000);
    chk("lu_next_nop",   f_nop, 5'b00000);
    tick();
    chk("lu_fwd_a",     f_fa,  2'b10);
    chk("lu_fwd_b",     f_fb,  2'b00);

    // forwarding priority on operand b
    set_idle();
    rs2_id = 5'd7; rs2_used = 1'b1; rd_ex = 5'd7; we_ex = 1'b1; rd_mem = 5'd7; we_mem = 1'b1;
    tick();
    chk("fp_ex_wins",   f_fb,  2'b01);
    chk("fp_a_unused",  f_fa,  2'b00);
    rd_ex = 5'd0;
    tick();
    chk("fp_mem",       f_fb,  2'b10);
    // dmem stall holds the forwarding select
    rd_mem = 5'd0; dbusy = 1'b1;
    #1;
    chk("fp_dbusy_stall", f_st,  5'b11110);
    chk("fp_dbusy_nop",   f_nop, 5'b00001);
    tick();
    chk("fp_hold",      f_fb,  2'b10);
    dbusy = 1'b0; rd_wb = 5'd7; we_wb = 1'b1;
    tick();
    chk("fp_wb_bypass", f_fb,  2'b00);
    rd_mem = 5'd7; rs2_used = 1'b0;
    tick();
    chk("fp_unused",    f_fb,  2'b00);

    // store hold, STORE_HOLD = 2
    set_idle();
    mem_write = 1'b1;
    #1;
    chk("sh_c0_stall",  f_st,  5'b11110);
    chk("sh_c0_nop",    f_nop, 5'b00001);
    tick();
    chk("sh_c1_state",  u_fwd.r_state, 2'd1);
    chk("sh_c1_stall",  f_st,  5'b11110);
    tick();
    chk("sh_c2_stall",  f_st,  5'b11110);
    chk("sh_c2_nop",    f_nop, 5'b00001);
    tick();
    chk("sh_done_state", u_fwd.r_state, 2'd2);
    chk("sh_done_stall", f_st,  5'b00000);
    chk("sh_done_nop",   f_nop, 5'b00000);
    tick();
    chk("sh_idle_state", u_fwd.r_state, 2'd0);
    mem_write = 1'b0;
    #1;
    chk("sh_no_rearm",  f_st,  5'b00000);
    tick();
    chk("sh_idle2",     u_fwd.r_state, 2'd0);

    // taken branch frozen under dmem stall, flushes on release
    set_idle();
    branch_taken = 1'b1; mem_read = 1'b1; dready_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("br_frz_stall", f_st,  5'b11110);
      chk("br_frz_nop",   f_nop, 5'b00001);
      tick();
    end
    dready_n = 1'b0;
    #1;
    chk("br_rel_stall", f_st,  5'b00000);
    chk("br_rel_nop",   f_nop, 5'b11110);
    chk("br_rel_nop_s2", i_nop, 5'b11100);
    tick();

    // branch flush beats load-use
    set_idle();
    branch_taken = 1'b1; load_ex = 1'b1; rd_ex = 5'd5; we_ex = 1'b1; rs1_id = 5'd5; rs1_used = 1'b1;
    #1;
    chk("brlu_stall",   f_st,  5'b00000);
    chk("brlu_nop",     f_nop, 5'b11110);
    tick();

    // stall-only interlock: producer walks EX -> MEM -> WB
    set_idle();
    rs1_id = 5'd9; rs1_used = 1'b1; rd_ex = 5'd9; we_ex = 1'b1;
    #1;
    chk("il_ex_stall",  i_st,  5'b11000);
    chk("il_ex_nop",    i_nop, 5'b00100);
    chk("il_fwdmode_free", f_st, 5'b00000);
    tick();
    chk("il_fwdmode_a", f_fa,  2'b01);
    rd_ex = 5'd0; we_ex = 1'b0; rd_mem = 5'd9; we_mem = 1'b1;
    #1;
    chk("il_mem_nop",   i_nop, 5'b00100);
    tick();
    rd_mem = 5'd0; we_mem = 1'b0; rd_wb = 5'd9; we_wb = 1'b1;
    #1;
    chk("il_wb_nop",    i_nop, 5'b00100);
    chk("il_wb_bypass", f_nop, 5'b00000);
    tick();
    rd_wb = 5'd0; we_wb = 1'b0;
    #1;
    chk("il_rel_stall", i_st,  5'b00000);
    chk("il_rel_nop",   i_nop, 5'b00000);
    chk("il_fwd_a",     i_fa,  2'b00);
    tick();

    // imem stall, and imem stall together with load-use
    set_idle();
    iready_n = 1'b1;
    #1;
    chk("im_stall",     f_st,  5'b10000);
    chk("im_nop",       f_nop, 5'b01000);
    tick();
    load_ex = 1'b1; rd_ex = 5'd4; we_ex = 1'b1; rs2_id = 5'd4; rs2_used = 1'b1;
    #1;
    chk("imlu_stall",   f_st,  5'b11000);
    chk("imlu_nop",     f_nop, 5'b00100);
    tick();

    // reset asserted in the middle of HOLD
    set_idle();
    rs1_id = 5'd3; rs1_used = 1'b1; rd_mem = 5'd3; we_mem = 1'b1;
    tick();
    chk("rh_fwd_pre",   f_fa,  2'b10);
    mem_write = 1'b1;
    tick();
    chk("rh_in_hold",   u_fwd.r_state, 2'd1);
    #1 rst = 1'b1;
    #1;
    chk("rh_stall",     f_st,  5'b00000);
    chk("rh_nop",       f_nop, 5'b11111);
    chk("rh_state",     u_fwd.r_state, 2'd0);
    chk("rh_cnt",       u_fwd.r_cnt,   2'd0);
    chk("rh_fwd",       f_fa,  2'b00);
    set_idle();
    #1 rst = 1'b0;
    #1;
    chk("rh_after_stall", f_st, 5'b00000);
    tick();
    chk("rh_after_state", u_fwd.r_state, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
